// File: rtl/logic2048_move_ctrl.sv
// 2048 move controller. The FSM merges the board one line per cycle
// through a single line merger, spawns a random tile, then re-evaluates the
// win and game-over flags. Cells are 4-bit exponents; i = row*4 + col.

module logic2048SingleLine (
    input  logic [3:0][3:0] line_in,
    output logic [3:0][3:0] line_out
);
    logic [4:0][3:0] packed_line;
    logic [2:0]      fill;
    logic [2:0]      wr;
    logic            skip;

    // Compact nonzero tiles toward x0, then merge each equal adjacent pair once.
    always_comb begin
        packed_line = '0;
        fill        = '0;
        for (int i = 0; i < 4; i++) begin
            if (line_in[i] != 4'd0) begin
                packed_line[fill] = line_in[i];
                fill              = fill + 3'd1;
            end
        end
        line_out = '0;
        wr       = '0;
        skip     = 1'b0;
        // packed_line[4] is always zero, so the last slot never pairs up.
        for (int i = 0; i < 4; i++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (packed_line[i] != 4'd0) begin
                if (packed_line[i] == packed_line[i+1]) begin
                    line_out[wr[1:0]] = packed_line[i] + 4'd1;
                    skip              = 1'b1;
                end else begin
                    line_out[wr[1:0]] = packed_line[i];
                end
                wr = wr + 3'd1;
            end
        end
    end
endmodule

module logic2048_move_ctrl #(
    parameter int          WIN_EXP   = 11,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_dir,
    output logic        cmd_ready,
    input  logic        new_game,
    input  logic        load_valid,
    input  logic [63:0] load_board,
    output logic [63:0] board,
    output logic        busy,
    output logic        done,
    output logic        moved,
    output logic        win,
    output logic        game_over
);
    localparam logic [3:0] WIN_V = 4'(WIN_EXP);

    typedef enum logic [2:0] {IDLE, MERGE, SPAWN, CHECK, DONE} state_t;

    state_t           state;
    logic [15:0][3:0] cells;
    logic [15:0]      lfsr;
    logic [1:0]       dir_q;
    logic [1:0]       line_cnt;
    logic [3:0]       scan_ptr;
    logic [3:0]       scan_cnt;
    logic             spawn_left;
    logic             moved_q;
    logic             win_q;
    logic             over_q;
    logic             done_q;

    logic [3:0][3:0]  line_idx;
    logic [3:0][3:0]  line_in;
    logic [3:0][3:0]  line_out;
    logic             line_diff;
    logic             any_empty;
    logic             any_pair;
    logic             any_win;
    logic             spawn_hit;
    logic             spawn_end;
    logic [3:0]       spawn_val;

    // Map (direction, line, position) to a cell index {row, col}; x0 is the
    // edge the tiles slide toward.
    function automatic logic [3:0] cell_idx(input logic [1:0] d,
                                            input logic [1:0] ln,
                                            input logic [1:0] pos);
        case (d)
            2'd0:    return {ln, pos};
            2'd1:    return {ln, ~pos};
            2'd2:    return {pos, ln};
            default: return {~pos, ln};
        endcase
    endfunction

    logic2048SingleLine u_line (
        .line_in  (line_in),
        .line_out (line_out)
    );

    // Gather the current line and board-wide status used by MERGE/SPAWN/CHECK.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            line_idx[k] = cell_idx(dir_q, line_cnt, 2'(k));
            line_in[k]  = cells[line_idx[k]];
        end
        line_diff = (line_out != line_in);
        any_empty = 1'b0;
        any_pair  = 1'b0;
        any_win   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (cells[i] == 4'd0)  any_empty = 1'b1;
            if (cells[i] >= WIN_V) any_win   = 1'b1;
        end
        for (int i = 0; i < 15; i++) begin
            if (((i & 3) != 3) && (cells[i] == cells[i+1])) any_pair = 1'b1;
        end
        for (int i = 0; i < 12; i++) begin
            if (cells[i] == cells[i+4]) any_pair = 1'b1;
        end
        spawn_hit = (cells[scan_ptr] == 4'd0);
        spawn_end = spawn_hit || (scan_cnt == 4'd15);
        spawn_val = (lfsr[7:4] == 4'd0) ? 4'd2 : 4'd1;
    end

    // Free-running Galois LFSR; advances every cycle, including IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= LFSR_SEED;
        else        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    // Main FSM together with the board datapath and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cells      <= '0;
            dir_q      <= '0;
            line_cnt   <= '0;
            scan_ptr   <= '0;
            scan_cnt   <= '0;
            spawn_left <= 1'b0;
            moved_q    <= 1'b0;
            win_q      <= 1'b0;
            over_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        cells   <= load_board;
                        moved_q <= 1'b0;
                        win_q   <= 1'b0;
                        state   <= CHECK;
                    end else if (new_game) begin
                        cells      <= '0;
                        moved_q    <= 1'b0;
                        win_q      <= 1'b0;
                        spawn_left <= 1'b1;
                        scan_ptr   <= lfsr[3:0];
                        scan_cnt   <= '0;
                        state      <= SPAWN;
                    end else if (cmd_valid) begin
                        dir_q    <= cmd_dir;
                        line_cnt <= '0;
                        moved_q  <= 1'b0;
                        state    <= MERGE;
                    end
                end
                MERGE: begin
                    for (int k = 0; k < 4; k++) cells[line_idx[k]] <= line_out[k];
                    if (line_diff) moved_q <= 1'b1;
                    line_cnt <= line_cnt + 2'd1;
                    if (line_cnt == 2'd3) begin
                        spawn_left <= 1'b0;
                        scan_ptr   <= lfsr[3:0];
                        scan_cnt   <= '0;
                        state      <= (moved_q || line_diff) ? SPAWN : CHECK;
                    end
                end
                SPAWN: begin
                    if (spawn_hit) cells[scan_ptr] <= spawn_val;
                    if (spawn_end) begin
                        // new_game places a second tile from a fresh scan start.
                        if (spawn_left) begin
                            spawn_left <= 1'b0;
                            scan_ptr   <= lfsr[3:0];
                            scan_cnt   <= '0;
                        end else begin
                            state <= CHECK;
                        end
                    end else begin
                        scan_ptr <= scan_ptr + 4'd1;
                        scan_cnt <= scan_cnt + 4'd1;
                    end
                end
                CHECK: begin
                    over_q <= !any_empty && !any_pair;
                    win_q  <= win_q | any_win;
                    done_q <= 1'b1;
                    state  <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign board     = cells;
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign moved     = moved_q;
    assign win       = win_q;
    assign game_over = over_q;
endmodule

// File: tb/tb_logic2048_move_ctrl.sv
// Directed bench for logic2048_move_ctrl: loads known boards, issues moves
// and checks results, flags, latency and reset behaviour.

module tb_logic2048_move_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic [1:0]  cmd_dir;
    logic        cmd_ready;
    logic        new_game;
    logic        load_valid;
    logic [63:0] load_board;
    logic [63:0] board;
    logic        busy;
    logic        done;
    logic        moved;
    logic        win;
    logic        game_over;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] m_lfsr;

    logic2048_move_ctrl #(.WIN_EXP(11), .LFSR_SEED(16'hACE1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_dir    (cmd_dir),
        .cmd_ready  (cmd_ready),
        .new_game   (new_game),
        .load_valid (load_valid),
        .load_board (load_board),
        .board      (board),
        .busy       (busy),
        .done       (done),
        .moved      (moved),
        .win        (win),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] s, input int n);
        logic [15:0] v;
        v = s;
        for (int i = 0; i < n; i++) v = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
        return v;
    endfunction

    // Reference LFSR, reset and stepped exactly like the one in the design.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= lfsr_adv(m_lfsr, 1);
    end

    // Exactly one cell differs from base; it was empty and now holds 1 or 2.
    function automatic logic one_new_tile(input logic [63:0] got, input logic [63:0] base);
        int   n;
        logic bad;
        logic [3:0] g, b;
        n = 0;
        bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            g = got[4*i +: 4];
            b = base[4*i +: 4];
            if (g != b) begin
                n++;
                if (b != 4'd0 || (g != 4'd1 && g != 4'd2)) bad = 1'b1;
            end
        end
        return (n == 1) && !bad;
    endfunction

    // Fresh game: exactly two nonzero cells, each 1 or 2.
    function automatic logic fresh_ok(input logic [63:0] got);
        int   n;
        logic bad;
        logic [3:0] g;
        n = 0;
        bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            g = got[4*i +: 4];
            if (g != 4'd0) begin
                n++;
                if (g != 4'd1 && g != 4'd2) bad = 1'b1;
            end
        end
        return (n == 2) && !bad;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int k0, output int k);
        k = k0;
        while (done !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", 64'(done), 64'd1);
    endtask

    task automatic do_load(input logic [63:0] b, output int k);
        @(negedge clk);
        load_valid = 1'b1;
        load_board = b;
        @(negedge clk);
        load_valid = 1'b0;
        wait_done(1, k);
    endtask

    task automatic do_cmd(input logic [1:0] d, output int k);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_dir   = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_done(1, k);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        int          guard;
        logic [15:0] t;
        logic [3:0]  exp_v;
        logic [63:0] b;

        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_dir    = 2'd0;
        new_game   = 1'b0;
        load_valid = 1'b0;
        load_board = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_board", board, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_flags", {61'd0, moved, win, game_over}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'(cmd_ready), 64'd1);

        // New game from reset
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        wait_done(1, k);
        chk("ng_tiles", 64'(fresh_ok(board)), 64'd1);
        chk("ng_win_over", {62'd0, win, game_over}, 64'd0);

        // Load row0 [1,1,2,2], then move left
        do_load(64'h0000_0000_0000_2211, k);
        chk("load_lat", 64'(k), 64'd2);
        chk("load_board", board, 64'h0000_0000_0000_2211);
        chk("load_flags", {61'd0, moved, win, game_over}, 64'd0);
        do_cmd(2'd0, k);
        chk("left_row0", {56'd0, board[7:0]}, 64'h32);
        chk("left_spawn", 64'(one_new_tile(board, 64'h0000_0000_0000_0032)), 64'd1);
        chk("left_moved", 64'(moved), 64'd1);
        chk("left_lat_range", 64'(k >= 7 && k <= 22), 64'd1);
        @(negedge clk);
        chk("done_pulse", {62'd0, done, cmd_ready}, 64'd1);

        // Right: row0 [0,0,1,1] -> cell3 = 2
        do_load(64'h0000_0000_0000_1100, k);
        do_cmd(2'd1, k);
        chk("right_tile", 64'(one_new_tile(board, 64'h0000_0000_0000_2000)), 64'd1);

        // Up: cells 8 and 12 hold 1 -> cell0 = 2
        do_load(64'h0001_0001_0000_0000, k);
        do_cmd(2'd2, k);
        chk("up_tile", 64'(one_new_tile(board, 64'h0000_0000_0000_0002)), 64'd1);

        // Locked board: no move, no spawn; a load during the move is ignored
        b = 64'h1212_2121_1212_2121;
        do_load(b, k);
        chk("lock_over_load", 64'(game_over), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_dir   = 2'd0;
        @(negedge clk);
        cmd_valid  = 1'b0;
        load_valid = 1'b1;
        load_board = '0;
        @(negedge clk);
        load_valid = 1'b0;
        wait_done(2, k);
        chk("lock_board", board, b);
        chk("lock_moved", 64'(moved), 64'd0);
        chk("lock_over", 64'(game_over), 64'd1);
        chk("lock_lat", 64'(k), 64'd6);

        // Win threshold: 10 is below, 11 reaches it
        do_load(64'h0000_0000_0000_000A, k);
        chk("win_below", 64'(win), 64'd0);
        do_load(64'h0000_0000_0000_000B, k);
        chk("win_at", 64'(win), 64'd1);
        do_load(64'h0000_0000_0000_00AA, k);
        chk("win_clr_load", 64'(win), 64'd0);
        do_cmd(2'd0, k);
        chk("merge_win_tile", 64'(one_new_tile(board, 64'h0000_0000_0000_000B)), 64'd1);
        chk("merge_win", 64'(win), 64'd1);
        chk("merge_win_over", 64'(game_over), 64'd0);
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        wait_done(1, k);
        chk("ng_win_clr", 64'(win), 64'd0);
        chk("ng2_tiles", 64'(fresh_ok(board)), 64'd1);

        // Spawn scan wrap: only cell 0 empty after down, scan starts at 15
        do_load(64'h9753_8642_9751_8641, k);
        @(negedge clk);
        guard = 0;
        t = lfsr_adv(m_lfsr, 4);
        while (t[3:0] != 4'hF && guard < 400) begin
            @(negedge clk);
            guard++;
            t = lfsr_adv(m_lfsr, 4);
        end
        chk("wrap_align", 64'(guard < 400), 64'd1);
        t = lfsr_adv(m_lfsr, 6);
        exp_v = (t[7:4] == 4'd0) ? 4'd2 : 4'd1;
        cmd_valid = 1'b1;
        cmd_dir   = 2'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_done(1, k);
        chk("wrap_lat", 64'(k), 64'd8);
        chk("wrap_board", board, {60'h9753_8642_9752_864, exp_v});
        chk("wrap_flags", {62'd0, moved, game_over}, 64'd2);

        // Reset in the middle of MERGE
        do_load(64'h0000_0000_0000_2211, k);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_dir   = 2'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_board", board, 64'd0);
        chk("mid_rst_busy", {62'd0, busy, cmd_ready}, 64'd1);
        chk("mid_rst_flags", {60'd0, done, moved, win, game_over}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_load(64'h0000_0000_0000_2211, k);
        do_cmd(2'd0, k);
        chk("post_rst_tile", 64'(one_new_tile(board, 64'h0000_0000_0000_0032)), 64'd1);
        chk("post_rst_moved", 64'(moved), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
